// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch return / decode handshake bundle for fetch_queue
//
// Purpose: groups the fetch-return push side, the flush, the decode-side
// valid/ready head outputs and the status outputs of fetch_queue.
// Ports (signals):
//   i_push, i_push_pc, i_push_inst0, i_push_inst1 : fetch return pair
//   i_flush                                       : redirect, empties queue
//   i_ready                                       : decode accepts head
//   o_valid, o_pc, o_inst0, o_inst1               : head entry to decode
//   o_stall                                       : hold PC register
//   o_count, o_overflow                           : occupancy, sticky drop error
// Modports: master = fetch/decode environment, slave = the queue.

interface fetch_queue_if #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                      i_push;
  logic [PC_WIDTH-1:0]       i_push_pc;
  logic [INST_WIDTH-1:0]     i_push_inst0;
  logic [INST_WIDTH-1:0]     i_push_inst1;
  logic                      i_flush;
  logic                      o_stall;
  logic                      o_valid;
  logic [PC_WIDTH-1:0]       o_pc;
  logic [INST_WIDTH-1:0]     o_inst0;
  logic [INST_WIDTH-1:0]     o_inst1;
  logic                      i_ready;
  logic [$clog2(DEPTH):0]    o_count;
  logic                      o_overflow;

  modport master (
    output i_push, i_push_pc, i_push_inst0, i_push_inst1, i_flush, i_ready,
    input  o_stall, o_valid, o_pc, o_inst0, o_inst1, o_count, o_overflow
  );

  modport slave (
    input  i_push, i_push_pc, i_push_inst0, i_push_inst1, i_flush, i_ready,
    output o_stall, o_valid, o_pc, o_inst0, o_inst1, o_count, o_overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetched instruction pairs feeding decode
//
// Purpose: captures {pc, inst0, inst1} returning from the 1-cycle instruction
// memory, buffers them, presents the head to decode with valid/ready, and
// stalls the PC register early enough that the in-flight fetch always fits.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   q     : fetch_queue_if.slave (push, flush, ready in; head, stall,
//           count, overflow out)

module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [INST_WIDTH-1:0] inst0_mem [DEPTH];
  logic [INST_WIDTH-1:0] inst1_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          drop_next;
  logic          overflow;

  logic pop;
  logic push_req;
  logic full;
  logic push_ok;

  // Flush wins over everything: no pop or push is counted in a flush cycle.
  assign pop      = (count != '0) & q.i_ready & ~q.i_flush;
  // The return arriving right after a flush belongs to the old PC stream.
  assign push_req = q.i_push & ~drop_next & ~q.i_flush;
  assign full     = (count == CW'(DEPTH));
  // A full queue can still take a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_next <= 1'b0;
      overflow  <= 1'b0;
    end else if (q.i_flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_next <= 1'b1;
    end else begin
      drop_next <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Entry storage carries no reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]    <= q.i_push_pc;
      inst0_mem[wr_ptr] <= q.i_push_inst0;
      inst1_mem[wr_ptr] <= q.i_push_inst1;
    end
  end

  assign q.o_valid    = (count != '0);
  // Stall one entry early so the fetch already issued still has a slot.
  assign q.o_stall    = (count >= CW'(DEPTH - 1));
  assign q.o_count    = count;
  assign q.o_overflow = overflow;
  assign q.o_pc       = pc_mem[rd_ptr];
  assign q.o_inst0    = inst0_mem[rd_ptr];
  assign q.o_inst1    = inst1_mem[rd_ptr];
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue

module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 32;
  localparam int IW    = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .INST_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  // Reference: expected contents in order, plus occupancy and flags.
  entry_t sb[$];
  int     m_cnt = 0;
  bit     m_drop = 1'b0;
  bit     m_ovf = 1'b0;

  bit     p_push = 1'b0;
  bit     p_flush = 1'b0;
  bit     p_ready = 1'b0;
  entry_t p_ent;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge using the inputs of that cycle.
  task automatic model_update();
    bit pop;
    if (p_flush) begin
      m_cnt  = 0;
      sb.delete();
      m_drop = 1'b1;
    end else begin
      pop = (m_cnt > 0) && p_ready;
      if (p_push && !m_drop) begin
        if (m_cnt < DEPTH || pop) begin
          sb.push_back(p_ent);
          m_cnt += 1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) m_cnt -= 1;
      m_drop = 1'b0;
    end
  endtask

  task automatic drive_idle();
    bus.i_push = 1'b0; bus.i_push_pc = '0; bus.i_push_inst0 = '0;
    bus.i_push_inst1 = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b0;
    p_push = 1'b0; p_flush = 1'b0; p_ready = 1'b0;
  endtask

  task automatic step(bit push, logic [31:0] pc, bit flush, bit ready);
    entry_t e;
    @(posedge clk);
    #1;
    model_update();
    e.pc = pc; e.i0 = $urandom; e.i1 = $urandom;
    bus.i_push = push; bus.i_push_pc = e.pc;
    bus.i_push_inst0 = e.i0; bus.i_push_inst1 = e.i1;
    bus.i_flush = flush; bus.i_ready = ready;
    p_push = push; p_flush = flush; p_ready = ready; p_ent = e;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_count", 32'(bus.o_count), 0);
    check("rst_valid", 32'(bus.o_valid), 0);
    check("rst_stall", 32'(bus.o_stall), 0);
    check("rst_ovf", 32'(bus.o_overflow), 0);
    #4;
    drive_idle();
    sb.delete();
    m_cnt = 0; m_drop = 1'b0; m_ovf = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares status every cycle and the head against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count", 32'(bus.o_count), 32'(m_cnt));
        check("valid", 32'(bus.o_valid), 32'(m_cnt != 0));
        check("stall", 32'(bus.o_stall), 32'(m_cnt >= DEPTH - 1));
        check("overflow", 32'(bus.o_overflow), 32'(m_ovf));
        if (bus.o_valid) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL head: valid=1 expected empty queue at %0t", $time);
          end else begin
            check("head_pc", bus.o_pc, sb[0].pc);
            check("head_inst0", bus.o_inst0, sb[0].i0);
            check("head_inst1", bus.o_inst1, sb[0].i1);
            if (bus.i_ready && !bus.i_flush) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    drive_idle();
    #3;
    check("init_valid", 32'(bus.o_valid), 0);
    check("init_stall", 32'(bus.o_stall), 0);
    check("init_count", 32'(bus.o_count), 0);
    check("init_ovf", 32'(bus.o_overflow), 0);
    #9;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Fill to the stall threshold, one more in flight, then drain.
    step(1, 32'h00, 0, 0);
    step(1, 32'h08, 0, 0);
    step(1, 32'h10, 0, 0);
    step(1, 32'h18, 0, 0);
    repeat (4) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);

    // Steady state push and pop, pointers wrap.
    step(1, 32'h100, 0, 0);
    for (int k = 1; k <= 10; k++) step(1, 32'h100 + 32'(8 * k), 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Flush with simultaneous push, stale return dropped, next accepted.
    step(1, 32'h300, 0, 0);
    step(1, 32'h308, 0, 0);
    step(1, 32'h40, 1, 0);
    step(1, 32'h48, 0, 0);
    step(1, 32'h200, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Overflow when full, then full push with pop accepted.
    for (int k = 0; k < 4; k++) step(1, 32'h400 + 32'(8 * k), 0, 0);
    step(1, 32'h500, 0, 0);
    step(1, 32'h508, 0, 1);
    step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Async reset with three entries queued, then first push accepted.
    for (int k = 0; k < 3; k++) step(1, 32'h700 + 32'(8 * k), 0, 0);
    step(0, 0, 0, 0);
    mid_reset();
    step(1, 32'h600, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Random segments; the last one follows the stall protocol.
    for (int seg = 0; seg < 4; seg++) begin
      mid_reset();
      pend = 1'b0;
      for (int c = 0; c < 400; c++) begin
        bit fl, rd, ps;
        fl = ($urandom_range(0, 19) == 0);
        rd = (seg == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
        ps = (seg == 3) ? pend : ($urandom_range(0, 3) != 0);
        step(ps, $urandom & 32'hFFFF_FFF8, fl, rd);
        pend = (m_cnt < DEPTH - 1) && ($urandom_range(0, 3) != 0);
      end
      step(0, 0, 0, 0);
      if (seg == 3) begin
        @(negedge clk);
        #1;
        check("compliant_no_overflow", 32'(bus.o_overflow), 0);
      end
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Receiving end of the fetch-address path in the 2-wide front end.
- Captures each fetched instruction pair {pc, inst0, inst1} from the synchronous instruction memory. The memory has 1-cycle read latency for the 8-byte-stride PC.
- Buffers pairs in a circular FIFO and hands them to decode with a valid/ready handshake.
- Drives the stall back to the PC register so no returning fetch is ever lost.

Parameters:
- DEPTH, 4, number of pair entries; power of two, >= 4.
- PC_WIDTH, 32, fetch address width (matches RV32_PC_WIDTH).
- INST_WIDTH, 32, width of one instruction.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_push  input  1  fetch return valid; upstream asserts one cycle after a non-stalled PC cycle.
- i_push_pc  input  PC_WIDTH  address of the returning pair (8-byte aligned).
- i_push_inst0  input  INST_WIDTH  instruction at i_push_pc.
- i_push_inst1  input  INST_WIDTH  instruction at i_push_pc+4.
- i_flush  input  1  redirect/flush; empties queue.
- o_stall  output  1  to PC register; hold PC while asserted.
- o_valid  output  1  head entry valid to decode.
- o_pc  output  PC_WIDTH  head entry pc.
- o_inst0  output  INST_WIDTH  head entry inst0.
- o_inst1  output  INST_WIDTH  head entry inst1.
- i_ready  input  1  decode accepts head this cycle.
- o_count  output  clog2(DEPTH)+1  current occupancy.
- o_overflow  output  1  sticky error: push dropped because queue full.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr, count = 0.
  - drop_next = 0.
  - o_overflow = 0.
  - o_stall = 0, o_valid = 0.
  - Entry storage is not reset; o_pc/o_inst* are don't-care while o_valid=0.
- Reset mid-operation discards all contents immediately; the first push after rst_n rises is accepted normally.
- Storage: DEPTH entries of {pc, inst0, inst1}; pointers wrap modulo DEPTH.
- Head outputs are combinational from entry[rd_ptr]. There is no bypass: a pushed pair is visible at the earliest on the cycle after the push.
- Pop = o_valid & i_ready. rd_ptr advances by 1. With o_valid=0, i_ready is ignored.
- Push = i_push & ~drop_next & ~i_flush:
  - count < DEPTH: write entry[wr_ptr], wr_ptr advances.
  - count == DEPTH and no pop in the same cycle: data discarded, o_overflow set (sticky until reset).
  - count == DEPTH with a pop in the same cycle: push accepted.
- Simultaneous push and pop: count unchanged, both pointers advance.
- o_valid = (count != 0).
- o_stall = (count >= DEPTH-1), combinational from registered count. This threshold leaves room for the one fetch in flight, so o_overflow never sets under a compliant upstream.
- Flush (highest priority):
  - wr_ptr=rd_ptr=0, count=0 on the next edge.
  - Any same-cycle push and pop are discarded; no pop is counted.
  - drop_next <= 1.
- drop_next:
  - In the cycle after a flush, i_push is discarded: it is the stale in-flight fetch from the old PC.
  - drop_next clears after that one cycle whether or not i_push was asserted.
  - A flush during the drop_next cycle sets it again.
- o_count reflects registered count; range 0..DEPTH.

Test Plan:
- Reset, then push pcs 0x00, 0x08, 0x10 on consecutive cycles with i_ready=0 -> o_count 1,2,3 on following cycles; o_stall=1 once count=3 (DEPTH=4); o_pc=0x00, o_valid=1.
- Continue from above, one more push (in flight, pc 0x18) -> count=4, o_overflow=0. Then assert i_ready 4 cycles -> o_pc sequence 0x00,0x08,0x10,0x18, inst0/inst1 match pushed values; o_valid=0 and o_stall=0 afterward.
- Steady state, push and pop every cycle for 10 cycles with pcs 0x100+8k -> count constant at 1; pointers wrap past DEPTH; output order exact.
- Queue holding 2 entries; i_flush with simultaneous push pc 0x40 -> next cycle count=0, o_valid=0. Push pc 0x48 on the following cycle -> dropped. Push pc 0x200 one cycle later -> accepted, o_pc=0x200.
- Full queue (count=4), push with i_ready=0 -> o_overflow=1 and stays 1, count stays 4. Same push coinciding with a pop -> accepted, o_overflow unchanged.
- Assert rst_n=0 asynchronously mid-cycle with count=3 -> o_valid, o_stall, o_count drop to 0 without waiting for a clock edge.
